// File: rtl/unidade_controle_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIO    = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        WB_R      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        EXCECAO   = 4'd12,
        ADDI_WB   = 4'd13
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle.sv
// Multicycle MIPS main control FSM with memory wait-state counter.
// Optional bne support is enabled by defining UNIDADE_CONTROLE_BNE_EN.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       excecao,
    output logic [3:0] estado
);

    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ultimo;
    logic          branch_taken;

    assign ultimo = (cnt_q == WAIT_LAST);
    assign estado = estado_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= INICIO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef UNIDADE_CONTROLE_BNE_EN
    logic eh_bne_q, eh_bne_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) eh_bne_q <= 1'b0;
        else          eh_bne_q <= eh_bne_d;
    end

    always_comb begin
        eh_bne_d = eh_bne_q;
        if (estado_q == DECODE) eh_bne_d = (opcode == OP_BNE);
    end

    assign branch_taken = eh_bne_q ? !zero : zero;
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIO:    estado_d = FETCH;
            FETCH:     if (ultimo) estado_d = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     estado_d = EXEC_R;
                    OP_LW, OP_SW: estado_d = MEM_ADDR;
                    OP_BEQ:       estado_d = BRANCH;
`ifdef UNIDADE_CONTROLE_BNE_EN
                    OP_BNE:       estado_d = BRANCH;
`endif
                    OP_J:         estado_d = JUMP;
                    OP_ADDI:      estado_d = ADDI_EXEC;
                    default:      estado_d = EXCECAO;
                endcase
            end
            MEM_ADDR:  estado_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (ultimo) estado_d = MEM_WB;
            MEM_WRITE: if (ultimo) estado_d = FETCH;
            EXEC_R:    estado_d = WB_R;
            ADDI_EXEC: estado_d = ADDI_WB;
            MEM_WB, WB_R, BRANCH, JUMP, ADDI_WB, EXCECAO: estado_d = FETCH;
            default:   estado_d = INICIO;
        endcase
        // Clearing on every transition covers entry to all waiting states.
        cnt_d = (estado_d != estado_q) ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_B;
        alu_op     = ALUOP_ADD;
        pc_source  = PCSRC_ALU;
        excecao    = 1'b0;
        unique case (estado_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = ultimo;
                pc_write  = ultimo;
            end
            DECODE:    alu_src_b = ALUB_IMM_SH;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = branch_taken;
            end
            JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ADDI_WB:   reg_write = 1'b1;
            EXCECAO:   excecao = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle (MEM_WAIT=1); honours UNIDADE_CONTROLE_BNE_EN.
module tb_unidade_controle;
    import unidade_controle_pkg::*;

    typedef struct packed {
        logic [3:0] est;
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       exc;
    } sig_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, excecao;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] estado;

    int checks = 0;
    int failures = 0;
    sig_t  exp_q[$];
    string name_q[$];

    unidade_controle #(.MEM_WAIT(1)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .excecao(excecao), .estado(estado)
    );

    always #5 clock = ~clock;

    function automatic sig_t actual();
        sig_t a;
        a = '{est: estado, pcw: pc_write, iord: iord, mrd: mem_read, mwr: mem_write,
              irw: ir_write, rdst: reg_dst, m2r: mem_to_reg, rw: reg_write,
              asa: alu_src_a, asb: alu_src_b, aop: alu_op, psrc: pc_source, exc: excecao};
        return a;
    endfunction

    function automatic void chk(string nm, sig_t a, sig_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endfunction

    // Hand-written expected output vectors, one per state.
    function automatic sig_t ex(estado_t st, bit flag);
        sig_t r;
        r = '0;
        r.est = st;
        case (st)
            FETCH:     begin r.mrd = 1; r.asb = 2'b01; r.irw = flag; r.pcw = flag; end
            DECODE:    r.asb = 2'b11;
            MEM_ADDR:  begin r.asa = 1; r.asb = 2'b10; end
            MEM_READ:  begin r.iord = 1; r.mrd = 1; end
            MEM_WB:    begin r.m2r = 1; r.rw = 1; end
            MEM_WRITE: begin r.iord = 1; r.mwr = 1; end
            EXEC_R:    begin r.asa = 1; r.aop = 2'b10; end
            WB_R:      begin r.rdst = 1; r.rw = 1; end
            BRANCH:    begin r.asa = 1; r.aop = 2'b01; r.psrc = 2'b01; r.pcw = flag; end
            JUMP:      begin r.psrc = 2'b10; r.pcw = 1; end
            ADDI_EXEC: begin r.asa = 1; r.asb = 2'b10; end
            ADDI_WB:   r.rw = 1;
            EXCECAO:   r.exc = 1;
            default:   ;
        endcase
        return r;
    endfunction

    task automatic cyc(input logic rn, input logic [5:0] opc, input logic z,
                       input sig_t e, input string nm);
        @(posedge clock);
        #1;
        reset_n = rn;
        opcode  = opc;
        zero    = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch2(input string tag);
        cyc(1'b1, 6'h00, 1'b0, ex(FETCH, 1'b0), {tag, "_fetch0"});
        cyc(1'b1, 6'h00, 1'b0, ex(FETCH, 1'b1), {tag, "_fetch1"});
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) chk(name_q.pop_front(), actual(), exp_q.pop_front());
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 1'b0, ex(INICIO, 1'b0), "reset_hold");
        cyc(1'b1, 6'h00, 1'b0, ex(INICIO, 1'b0), "inicio");
        fetch2("start");
        cyc(1'b1, OP_RTYPE, 1'b0, ex(DECODE, 1'b0), "r_decode");
        cyc(1'b1, OP_RTYPE, 1'b0, ex(EXEC_R, 1'b0), "r_exec");
        cyc(1'b1, OP_RTYPE, 1'b0, ex(WB_R, 1'b0), "r_wb");

        fetch2("lw");
        cyc(1'b1, OP_LW, 1'b0, ex(DECODE, 1'b0), "lw_decode");
        cyc(1'b1, OP_LW, 1'b0, ex(MEM_ADDR, 1'b0), "lw_addr");
        cyc(1'b1, OP_LW, 1'b0, ex(MEM_READ, 1'b0), "lw_read0");
        cyc(1'b1, OP_LW, 1'b0, ex(MEM_READ, 1'b0), "lw_read1");
        cyc(1'b1, OP_LW, 1'b0, ex(MEM_WB, 1'b0), "lw_wb");

        fetch2("sw");
        cyc(1'b1, OP_SW, 1'b0, ex(DECODE, 1'b0), "sw_decode");
        cyc(1'b1, OP_SW, 1'b0, ex(MEM_ADDR, 1'b0), "sw_addr");
        cyc(1'b1, OP_SW, 1'b0, ex(MEM_WRITE, 1'b0), "sw_write0");
        cyc(1'b1, OP_SW, 1'b0, ex(MEM_WRITE, 1'b0), "sw_write1");

        fetch2("beq1");
        cyc(1'b1, OP_BEQ, 1'b1, ex(DECODE, 1'b0), "beq1_decode");
        cyc(1'b1, OP_BEQ, 1'b1, ex(BRANCH, 1'b1), "beq1_branch");
        fetch2("beq0");
        cyc(1'b1, OP_BEQ, 1'b0, ex(DECODE, 1'b0), "beq0_decode");
        cyc(1'b1, OP_BEQ, 1'b0, ex(BRANCH, 1'b0), "beq0_branch");

        fetch2("j");
        cyc(1'b1, OP_J, 1'b0, ex(DECODE, 1'b0), "j_decode");
        cyc(1'b1, OP_J, 1'b0, ex(JUMP, 1'b0), "j_jump");

        fetch2("addi");
        cyc(1'b1, OP_ADDI, 1'b0, ex(DECODE, 1'b0), "addi_decode");
        cyc(1'b1, OP_ADDI, 1'b0, ex(ADDI_EXEC, 1'b0), "addi_exec");
        cyc(1'b1, OP_ADDI, 1'b0, ex(ADDI_WB, 1'b0), "addi_wb");

        fetch2("ill");
        cyc(1'b1, 6'h3F, 1'b0, ex(DECODE, 1'b0), "ill_decode");
        cyc(1'b1, 6'h3F, 1'b0, ex(EXCECAO, 1'b0), "ill_exc");

        fetch2("bne");
        cyc(1'b1, OP_BNE, 1'b0, ex(DECODE, 1'b0), "bne_decode");
`ifdef UNIDADE_CONTROLE_BNE_EN
        cyc(1'b1, OP_BNE, 1'b0, ex(BRANCH, 1'b1), "bne_branch");
`else
        cyc(1'b1, OP_BNE, 1'b0, ex(EXCECAO, 1'b0), "bne_exc");
`endif

        fetch2("rst");
        cyc(1'b1, OP_SW, 1'b0, ex(DECODE, 1'b0), "rst_decode");
        cyc(1'b1, OP_SW, 1'b0, ex(MEM_ADDR, 1'b0), "rst_addr");
        cyc(1'b1, OP_SW, 1'b0, ex(MEM_WRITE, 1'b0), "rst_write0");
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async", actual(), ex(INICIO, 1'b0));
        cyc(1'b0, 6'h00, 1'b0, ex(INICIO, 1'b0), "rst_hold");
        cyc(1'b1, 6'h00, 1'b0, ex(INICIO, 1'b0), "rst_inicio");
        fetch2("after_rst");
        cyc(1'b1, OP_J, 1'b0, ex(DECODE, 1'b0), "after_rst_decode");

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
